// File: rtl/img_spawn_queue.sv
// Spawn-index queue: filters the LFSR's 2-bit rand_num and buffers accepted indices for the sprite spawner.
// Optional macro SPAWN_NO_TRIPLE_EN rejects a third identical consecutive accepted index.
module img_spawn_queue #(
    parameter int DEPTH  = 4,
    parameter int WARMUP = 8
) (
    input  logic                     dclk,
    input  logic                     rst,
    input  logic [1:0]               rand_num,
    input  logic                     enable,
    input  logic                     pop,
    output logic                     img_valid,
    output logic [1:0]               img_idx,
    output logic [1:0]               next_idx,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               pop_total
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [7:0]    WARMUP_L = 8'(WARMUP);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN} state_t;

    state_t         state_q, state_d;
    logic [7:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [7:0]     pop_total_q, pop_total_d;
    logic [1:0]     mem_q [DEPTH];
    logic [1:0]     mem_d [DEPTH];
    logic           flush, run, pop_ok, push_ok, triple;

`ifdef SPAWN_NO_TRIPLE_EN
    logic [1:0]     h0_q, h0_d, h1_q, h1_d;
    logic           hv0_q, hv0_d, hv1_q, hv1_d;

    assign triple = hv0_q && hv1_q && (rand_num == h0_q) && (rand_num == h1_q);
`else
    assign triple = 1'b0;
`endif

    // Control FSM; every entry into (or stay in) IDLE flushes the queue.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    if (WARMUP == 0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_WARMUP;
                        wcnt_d  = WARMUP_L;
                    end
                end else begin
                    flush = 1'b1;
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    wcnt_d  = 8'd0;
                    flush   = 1'b1;
                end else if (wcnt_q <= 8'd1) begin
                    state_d = S_RUN;
                    wcnt_d  = 8'd0;
                end else begin
                    wcnt_d  = wcnt_q - 8'd1;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                flush   = 1'b1;
            end
        endcase
    end

    // A full queue still accepts a push when the head is popped in the same cycle.
    always_comb begin
        run     = (state_q == S_RUN) && enable;
        pop_ok  = run && pop && (count_q != '0);
        push_ok = run && (rand_num != 2'd3) && ((count_q < FULL) || pop_ok) && !triple;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = rand_num;
        end

        wr_ptr_d    = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        pop_total_d = pop_ok  ? pop_total_q + 8'd1 : pop_total_q;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pop_total_d = 8'd0;
        end
    end

`ifdef SPAWN_NO_TRIPLE_EN
    always_comb begin
        h0_d  = h0_q;
        h1_d  = h1_q;
        hv0_d = hv0_q;
        hv1_d = hv1_q;
        if (push_ok) begin
            h1_d  = h0_q;
            h0_d  = rand_num;
            hv1_d = hv0_q;
            hv0_d = 1'b1;
        end
        if (flush) begin
            hv0_d = 1'b0;
            hv1_d = 1'b0;
        end
    end

    always_ff @(posedge dclk) begin
        h0_q <= h0_d;
        h1_q <= h1_d;
        if (rst) begin
            hv0_q <= 1'b0;
            hv1_q <= 1'b0;
        end else begin
            hv0_q <= hv0_d;
            hv1_q <= hv1_d;
        end
    end
`endif

    always_ff @(posedge dclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_total_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_total_q <= pop_total_d;
        end
    end

    // Storage is not reset; outputs are masked by count instead.
    always_ff @(posedge dclk) begin
        mem_q <= mem_d;
    end

    assign img_valid = (count_q != '0);
    assign img_idx   = img_valid ? mem_q[rd_ptr_q] : 2'd0;
    assign next_idx  = (count_q >= (AW+1)'(2)) ? mem_q[rd_ptr_q + AW'(1)] : 2'd0;
    assign count     = count_q;
    assign pop_total = pop_total_q;

endmodule

// File: doc/img_spawn_queue.md
# img_spawn_queue

Buffers image indices for spawning. It sits directly downstream of the LFSR random-index generator and samples its 2-bit `rand_num` output on every `dclk`. Invalid codes and (optionally) three-in-a-row repeats are rejected. Accepted indices are held in a small FIFO, from which the game-object spawner pops one index per spawned sprite through a valid/pop handshake.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥2.
- `WARMUP`, default 8: `dclk` cycles of `rand_num` discarded after leaving IDLE. Range 0..255.

Ports:
- `dclk`: input, 1 bit. Clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Reset, synchronous, active-high.
- `rand_num`: input, 2 bits. Candidate image index from the random generator; values 0..2 are valid, 3 is invalid.
- `enable`: input, 1 bit. Run request; low forces IDLE and flushes the queue.
- `pop`: input, 1 bit. Consumer takes the head entry; effective only when `img_valid`=1.
- `img_valid`: output, 1 bit. Queue is non-empty.
- `img_idx`: output, 2 bits. Head entry; 0 when empty.
- `next_idx`: output, 2 bits. Second entry (preview); 0 when `count`<2.
- `count`: output, $clog2(DEPTH)+1 bits. Occupancy.
- `pop_total`: output, 8 bits. Accepted pops since reset or flush; wraps 255→0.

## Operation
- Reset values: state=IDLE, `count`=0, `img_valid`=0, `img_idx`=0, `next_idx`=0, `pop_total`=0, history registers `h1`/`h0` marked empty, warmup counter=0.
- FSM states:
  - IDLE: no pushes.
    - `enable`=1 → WARMUP with the counter loaded to WARMUP.
    - If WARMUP=0, go directly to RUN.
  - WARMUP: decrement the counter each cycle; no pushes.
    - Counter reaching 1 → RUN on the next edge, so exactly WARMUP cycles are skipped.
    - `enable`=0 → IDLE.
  - RUN: push logic active.
    - `enable`=0 → IDLE.
- Flush: any transition into IDLE, and reset.
  - Clears FIFO pointers, `count`, history and `pop_total` in the same edge.
  - A `pop` in that same cycle is ignored.
- Push candidate each RUN cycle: `rand_num`. Accepted iff all of the following hold:
  - `rand_num` != 3.
  - Room exists: `count` < DEPTH, or an accepted pop occurs the same cycle.
  - Not a triple (only when the filter is compiled in; see Configuration).
- Accepted push:
  - Writes the value at the write pointer.
  - Shifts history: `h1`←`h0`, `h0`←value.
  - Rejected candidates leave history unchanged.
- Pop accepted iff `pop`=1 and `count`>0:
  - Advances the read pointer.
  - Increments `pop_total`.
- Pop on empty has no effect.
- Simultaneous push and pop: `count` unchanged; both pointers advance.
- Pointers are mod DEPTH and wrap naturally. `count` never exceeds DEPTH and never underflows.
- Outputs are derived from registered state only; there are no combinational paths from `rand_num` or `pop` to outputs.

## Timing
- Push latency: a `rand_num` sampled at edge N is reflected in `count`/`img_valid` immediately after edge N. If the queue was empty, it also appears on `img_idx` then.
- Pop latency: `pop` sampled at edge N; the new head appears on `img_idx` after edge N.
- Sustained rate: one push and one pop per cycle.
- From `enable` rising, the first push occurs at the WARMUP+2nd edge: 1 edge IDLE→WARMUP, then WARMUP edges.
- `enable` falling at edge N: queue empty and `img_valid`=0 after edge N.
- `rst` mid-operation overrides everything, identical to power-up reset.

## Configuration
- Macro `SPAWN_NO_TRIPLE_EN`.
  - Defined: a candidate equal to both `h0` and `h1`, with both history registers valid, is rejected. No three identical consecutive accepted indices are ever produced.
  - Undefined: there is no history check; the history registers may be removed. Only the invalid-code and room rules apply.

## Test plan
- Reset/defaults:
  - Stimulus: assert `rst` for 2 cycles with `enable`=1 and `pop`=1.
  - Required: all outputs 0, state IDLE, no pushes.
- Warmup and fill:
  - Stimulus: WARMUP=8, `rand_num` cycling 0,1,2, `enable` rises.
  - Required: `count` still 0 after 9 edges; then +1 per edge until `count`=4. The queue holds the first four RUN-cycle values in order.
- Invalid code and triple filter:
  - Stimulus: `rand_num` held at 1 in RUN, empty queue, with `SPAWN_NO_TRIPLE_EN` defined.
  - Required: `count` stops at 2.
  - Without the macro: `count` reaches 4.
  - `rand_num`=3 held: `count` stays 0 in both builds.
- Full with pop:
  - Stimulus: `count`=4, `pop`=1 continuously, valid non-triple input.
  - Required: `count` stays 4; `pop_total` increments each cycle; `img_idx` follows FIFO order across pointer wrap.
- Empty pop and preview:
  - Stimulus: `pop` on empty queue.
  - Required: `pop_total` unchanged.
  - Stimulus: push 2 then 0.
  - Required: `img_idx`=2, `next_idx`=0.
- Mid-run disable and reset:
  - Stimulus: drop `enable` with `count`=3 and `pop`=1.
  - Required: after that edge, `count`=0, `pop_total`=0, IDLE.
  - Stimulus: assert `rst` during WARMUP.
  - Required: returns to IDLE with all outputs 0.
